// File: rtl/cond_unit.sv
// Conditional-execution stage: stored NZCV flags, condition check, commit gating, exec/squash counters.
// Zero-latency combinational commit outputs; flags and counters update on the rising clk edge; no backpressure.
module cond_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagWrite,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic [3:0]       BeIn,
  input  logic             InstrValid,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [3:0]       BeOut,
  output logic [3:0]       Flags,
  output logic             CondEx,
  output logic [CNT_W-1:0] ExecCount,
  output logic [CNT_W-1:0] SquashCount
);

  logic n, z, c, v;
  logic go;

  assign {n, z, c, v} = Flags;

  // Evaluated against stored flags only, so an instruction cannot see its own flag update.
  always_comb begin
    CondEx = 1'b0;
    unique case (Cond)
      4'b0000: CondEx = z;
      4'b0001: CondEx = ~z;
      4'b0010: CondEx = c;
      4'b0011: CondEx = ~c;
      4'b0100: CondEx = n;
      4'b0101: CondEx = ~n;
      4'b0110: CondEx = v;
      4'b0111: CondEx = ~v;
      4'b1000: CondEx = c & ~z;
      4'b1001: CondEx = ~c | z;
      4'b1010: CondEx = (n == v);
      4'b1011: CondEx = (n != v);
      4'b1100: CondEx = ~z & (n == v);
      4'b1101: CondEx = z | (n != v);
      default: CondEx = 1'b1;
    endcase
  end

  assign go       = CondEx & InstrValid;
  assign PCSrc    = PCS & go;
  assign RegWrite = RegW & go;
  assign MemWrite = MemW & go;
  assign BeOut    = go ? BeIn : 4'b0000;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Flags <= 4'b0000;
    end else begin
      if (FlagWrite[1] & go) Flags[3:2] <= ALUFlags[3:2];
      if (FlagWrite[0] & go) Flags[1:0] <= ALUFlags[1:0];
    end
  end

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ExecCount   <= '0;
      SquashCount <= '0;
    end else if (InstrValid) begin
      if (CondEx) begin
        if (ExecCount != '1) ExecCount <= ExecCount + CNT_W'(1);
      end else begin
        if (SquashCount != '1) SquashCount <= SquashCount + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cond_unit.sv
// Directed bench for cond_unit with a queue scoreboard fed by a reference model of flags and counters.
module tb_cond_unit;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   Cond, ALUFlags, BeIn, BeOut, Flags;
  logic [1:0]   FlagWrite;
  logic         PCS, RegW, MemW, InstrValid;
  logic         PCSrc, RegWrite, MemWrite, CondEx;
  logic [W-1:0] ExecCount, SquashCount;

  cond_unit #(.CNT_W(W)) dut (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagWrite(FlagWrite),
    .PCS(PCS), .RegW(RegW), .MemW(MemW), .BeIn(BeIn), .InstrValid(InstrValid),
    .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite), .BeOut(BeOut),
    .Flags(Flags), .CondEx(CondEx), .ExecCount(ExecCount), .SquashCount(SquashCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       pcsrc, regwrite, memwrite, condex;
    logic [3:0] be, flags;
  } comb_t;

  typedef struct {
    logic [3:0]   flags;
    logic [W-1:0] ex, sq;
  } state_t;

  comb_t  comb_q[$];
  state_t state_q[$];

  int nvec  = 0;
  int nfail = 0;

  logic [3:0]   m_flags;
  logic [W-1:0] m_ex, m_sq;

  // Reference: base condition on Cond[3:1], odd codes invert it; 111x is always.
  function automatic logic ref_cond(input logic [3:0] cc, input logic [3:0] f);
    logic b;
    case (cc[3:1])
      3'd0: b = f[2];
      3'd1: b = f[1];
      3'd2: b = f[3];
      3'd3: b = f[0];
      3'd4: b = f[1] & ~f[2];
      3'd5: b = (f[3] == f[0]);
      3'd6: b = ~f[2] & (f[3] == f[0]);
      default: return 1'b1;
    endcase
    return b ^ cc[0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_flags = 4'b0000;
    m_ex    = '0;
    m_sq    = '0;
  endtask

  // Drive one instruction, check commit outputs mid-cycle, then check state after the edge.
  task automatic apply(input logic [3:0] c, input logic [3:0] alu, input logic [1:0] fw,
                       input logic pcs, input logic regw, input logic memw,
                       input logic [3:0] be, input logic iv);
    comb_t  ce, ca;
    state_t se, sa;
    logic   pass, g;
    Cond = c; ALUFlags = alu; FlagWrite = fw; PCS = pcs; RegW = regw;
    MemW = memw; BeIn = be; InstrValid = iv;
    pass = ref_cond(c, m_flags);
    g    = pass & iv;
    ce.pcsrc = pcs & g; ce.regwrite = regw & g; ce.memwrite = memw & g;
    ce.condex = pass; ce.be = g ? be : 4'b0000; ce.flags = m_flags;
    comb_q.push_back(ce);
    if (g && fw[1]) m_flags[3:2] = alu[3:2];
    if (g && fw[0]) m_flags[1:0] = alu[1:0];
    if (iv && pass && m_ex != {W{1'b1}}) m_ex = m_ex + 1'b1;
    if (iv && !pass && m_sq != {W{1'b1}}) m_sq = m_sq + 1'b1;
    se.flags = m_flags; se.ex = m_ex; se.sq = m_sq;
    state_q.push_back(se);
    #1;
    ca = comb_q.pop_front();
    check("condex",   32'(CondEx),   32'(ca.condex));
    check("pcsrc",    32'(PCSrc),    32'(ca.pcsrc));
    check("regwrite", 32'(RegWrite), 32'(ca.regwrite));
    check("memwrite", 32'(MemWrite), 32'(ca.memwrite));
    check("beout",    32'(BeOut),    32'(ca.be));
    check("flags_pre", 32'(Flags),   32'(ca.flags));
    @(posedge clk);
    #1;
    sa = state_q.pop_front();
    check("flags",  32'(Flags),       32'(sa.flags));
    check("exec",   32'(ExecCount),   32'(sa.ex));
    check("squash", 32'(SquashCount), 32'(sa.sq));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    Cond = 4'b1110; ALUFlags = 4'b0000; FlagWrite = 2'b00; PCS = 1'b0;
    RegW = 1'b0; MemW = 1'b0; BeIn = 4'b0000; InstrValid = 1'b0;
    model_reset();
    #12;
    check("rst_flags",  32'(Flags),       32'd0);
    check("rst_exec",   32'(ExecCount),   32'd0);
    check("rst_squash", 32'(SquashCount), 32'd0);
    check("rst_condex", 32'(CondEx),      32'd1);
    reset = 1'b0;

    // EQ with Z clear: squashed, register write suppressed.
    apply(4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1);
    // AL loads Z, then EQ passes and commits the store.
    apply(4'b1110, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
    apply(4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 4'b1111, 1'b1);
    // Partial writes: only CV loads; then a squashed NE leaves flags alone.
    apply(4'b1110, 4'b1011, 2'b01, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
    apply(4'b1110, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
    apply(4'b0001, 4'b1011, 2'b10, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
    // Bubble: nothing commits, no counter moves.
    apply(4'b1110, 4'b1111, 2'b11, 1'b0, 1'b1, 1'b1, 4'b1010, 1'b0);

    // Every condition against every flag value.
    for (int f = 0; f < 16; f++) begin
      apply(4'b1110, 4'(f), 2'b11, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
      for (int c = 0; c < 16; c++)
        apply(4'(c), 4'(~f), 2'b00, 1'b1, 1'b1, 1'b0, 4'b0101, 1'b1);
    end

    // Saturation from a clean start, then asynchronous reset between edges.
    reset = 1'b1; #1; model_reset(); reset = 1'b0;
    apply(4'b1110, 4'b1010, 2'b11, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
    for (int i = 0; i < 19; i++)
      apply(4'b1110, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1);
    check("sat_exec", 32'(ExecCount), 32'd15);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("async_exec",  32'(ExecCount), 32'd0);
    check("async_flags", 32'(Flags),     32'd0);
    #2;
    reset = 1'b0;
    apply(4'b1110, 4'b1100, 2'b10, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
